// File: rtl/yolo_dma_pkg.sv
// Shared constants, transfer type codes and FSM state encoding for the YOLO DDR
// command generator.
package yolo_dma_pkg;

   localparam int unsigned DefBeatBytes = 32;
   localparam int unsigned DefMaxBurst  = 16;

   localparam logic [31:0] Reg5Addr   = 32'hC000_0014;
   localparam logic [31:0] TypeInput  = 32'h0000_0000;
   localparam logic [31:0] TypeWeight = 32'h0000_0010;
   localparam logic [31:0] TypeOutput = 32'h0000_0020;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StIssue,
      StWait,
      StDone
   } state_t;

   function automatic logic type_is_known(input logic [31:0] code);
      return (code == TypeInput) || (code == TypeWeight) || (code == TypeOutput);
   endfunction

endpackage

// File: rtl/yolo_burst_calc.sv
// Size of the next DDR burst: the smallest of the beats left, the burst cap and
// the beats remaining before the next 4 KB page boundary.
module yolo_burst_calc
   import yolo_dma_pkg::*;
#(
   parameter int unsigned BEAT_BYTES = DefBeatBytes,
   parameter int unsigned MAX_BURST  = DefMaxBurst
) (
   input  logic [32:0] remaining,
   input  logic [11:0] addr_lo,
   output logic [8:0]  beats
);

   localparam logic [32:0] BeatBytesW = 33'(BEAT_BYTES);
   localparam logic [32:0] MaxBurstW  = 33'(MAX_BURST);

   logic [32:0] room;
   logic [32:0] limit;

   always_comb begin
      room  = (33'd4096 - {21'd0, addr_lo}) / BeatBytesW;
      limit = (room < MaxBurstW) ? room : MaxBurstW;
      beats = (remaining < limit) ? 9'(remaining) : 9'(limit);
   end

endmodule

// File: rtl/yolo_ddr_cmd_gen.sv
// Turns a snooped ICB write to the reg5 trigger address into a sequence of
// page-safe DDR burst commands, one outstanding at a time.
module yolo_ddr_cmd_gen
   import yolo_dma_pkg::*;
#(
   parameter int unsigned BEAT_BYTES = DefBeatBytes,
   parameter int unsigned MAX_BURST  = DefMaxBurst
) (
   input  logic        sys_clk_50m,
   input  logic        hard_rst,
   input  logic        s6_icb_cmd_valid,
   input  logic [31:0] s6_icb_cmd_addr,
   input  logic        s6_icb_cmd_read,
   input  logic [31:0] s6_icb_cmd_wdata,
   input  logic [31:0] slave_lite_reg4,
   input  logic [31:0] slave_lite_reg6,
   output logic        ddr_cmd_valid,
   input  logic        ddr_cmd_ready,
   output logic [31:0] ddr_cmd_addr,
   output logic [7:0]  ddr_cmd_len,
   output logic        ddr_cmd_dir,
   output logic        ddr_cmd_to_yolo,
   input  logic        ddr_burst_done,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        overrun
);

   localparam logic [32:0] BeatBytesW  = 33'(BEAT_BYTES);
   localparam logic [31:0] BeatBytes32 = 32'(BEAT_BYTES);

   state_t      state_q, state_d;
   logic [31:0] type_q, type_d;
   logic [31:0] len_q, len_d;
   logic [31:0] addr_q, addr_d;
   logic [32:0] remaining_q, remaining_d;
   logic        err_q, err_d;
   logic        overrun_q, overrun_d;

   logic        trigger;
   logic        aligned;
   logic [32:0] total_beats;
   logic [8:0]  beats;

   assign trigger = s6_icb_cmd_valid & ~s6_icb_cmd_read & (s6_icb_cmd_addr == Reg5Addr);

   yolo_burst_calc #(
      .BEAT_BYTES(BEAT_BYTES),
      .MAX_BURST (MAX_BURST)
   ) u_burst_calc (
      .remaining(remaining_q),
      .addr_lo  (addr_q[11:0]),
      .beats    (beats)
   );

   always_comb begin
      aligned     = (addr_q % BeatBytes32) == 32'd0;
      // 33 bits so a length near 4 GB cannot wrap when rounding up.
      total_beats = ({1'b0, len_q} + BeatBytesW - 33'd1) / BeatBytesW;

      state_d     = state_q;
      type_d      = type_q;
      len_d       = len_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      err_d       = 1'b0;
      overrun_d   = overrun_q;

      unique case (state_q)
         StIdle: begin
            if (trigger) begin
               type_d    = s6_icb_cmd_wdata;
               len_d     = slave_lite_reg4;
               addr_d    = slave_lite_reg6;
               overrun_d = 1'b0;
               state_d   = StCheck;
            end
         end
         StCheck: begin
            if (!type_is_known(type_q) || !aligned) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else if (len_q == 32'd0) begin
               state_d = StDone;
            end else begin
               remaining_d = total_beats;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            if (ddr_cmd_ready) begin
               addr_d      = addr_q + ({23'd0, beats} * BeatBytes32);
               remaining_d = remaining_q - {24'd0, beats};
               state_d     = StWait;
            end
         end
         StWait: begin
            if (ddr_burst_done) begin
               state_d = (remaining_q != 33'd0) ? StIssue : StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // DONE counts as busy, so a trigger there is dropped too.
      if (trigger && (state_q != StIdle)) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk_50m) begin
      if (hard_rst) begin
         state_q     <= StIdle;
         type_q      <= '0;
         len_q       <= '0;
         addr_q      <= '0;
         remaining_q <= '0;
         err_q       <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         err_q       <= err_d;
         overrun_q   <= overrun_d;
      end
   end

   // Command fields read as zero whenever no command is being offered.
   assign ddr_cmd_valid   = (state_q == StIssue);
   assign ddr_cmd_addr    = ddr_cmd_valid ? addr_q : 32'd0;
   assign ddr_cmd_len     = ddr_cmd_valid ? 8'(beats - 9'd1) : 8'd0;
   assign ddr_cmd_dir     = ddr_cmd_valid & (type_q == TypeOutput);
   assign ddr_cmd_to_yolo = ddr_cmd_valid & (type_q == TypeOutput);

   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StDone);
   assign err     = err_q;
   assign overrun = overrun_q;

endmodule

// File: doc/yolo_ddr_cmd_gen.md
YOLO_DDR_CMD_GEN -- requirements
Module: yolo_ddr_cmd_gen

Interface
REQ-001 SHALL have parameter BEAT_BYTES, default 32: bytes per DDR data beat (256-bit bus).
REQ-002 SHALL have parameter MAX_BURST, default 16: maximum beats per DDR command.
REQ-003 SHALL have port sys_clk_50m, input, 1: sole clock.
REQ-004 SHALL have port hard_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port s6_icb_cmd_valid, input, 1: snooped ICB command valid.
REQ-006 SHALL have port s6_icb_cmd_addr, input, 32: snooped ICB address.
REQ-007 SHALL have port s6_icb_cmd_read, input, 1: snooped ICB read flag (0 = write).
REQ-008 SHALL have port s6_icb_cmd_wdata, input, 32: snooped ICB write data.
REQ-009 SHALL have port slave_lite_reg4, input, 32: transfer length in bytes.
REQ-010 SHALL have port slave_lite_reg6, input, 32: DDR byte start address.
REQ-011 SHALL have port ddr_cmd_valid, output, 1: burst command valid.
REQ-012 SHALL have port ddr_cmd_ready, input, 1: burst command accepted.
REQ-013 SHALL have port ddr_cmd_addr, output, 32: burst start byte address.
REQ-014 SHALL have port ddr_cmd_len, output, 8: beats minus one.
REQ-015 SHALL have port ddr_cmd_dir, output, 1: 0 = write into DDR, 1 = read from DDR.
REQ-016 SHALL have port ddr_cmd_to_yolo, output, 1: read data is routed to the YOLO engine.
REQ-017 SHALL have port ddr_burst_done, input, 1: one-cycle pulse when the outstanding burst's data phase completes.
REQ-018 SHALL have ports busy (1), done (1, pulse), err (1, pulse) and overrun (1, sticky) as outputs.

Function
REQ-019 Trigger SHALL be s6_icb_cmd_valid & ~s6_icb_cmd_read & s6_icb_cmd_addr==32'hC0000014 in IDLE.
REQ-020 On trigger, the block SHALL capture type from s6_icb_cmd_wdata, length from slave_lite_reg4, and address from slave_lite_reg6, all in the same cycle.
REQ-021 Type 0x00 (input data) and 0x10 (bias/weights) SHALL give dir=0, to_yolo=0; type 0x20 SHALL give dir=1, to_yolo=1.
REQ-022 Any other type, or address[4:0]!=0, SHALL produce err for one cycle two cycles after the trigger, issue no command, and return to IDLE.
REQ-023 Total beats SHALL be ceil(len/BEAT_BYTES), computed 33-bit wide with no overflow.
REQ-024 len==0 SHALL produce done two cycles after the trigger with no command.
REQ-025 The state machine SHALL be IDLE -> CHECK -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE; CHECK and DONE each last one cycle.
REQ-026 Each burst SHALL be min(remaining, MAX_BURST, (4096 - addr[11:0])/BEAT_BYTES) beats, so that no burst crosses a 4 KB boundary.
REQ-027 ddr_cmd_valid SHALL assert in ISSUE, with all ddr_cmd_* fields held stable until the cycle where ddr_cmd_ready is high; the FSM then moves to WAIT.
REQ-028 After each accepted burst, address SHALL advance by beats*BEAT_BYTES and remaining SHALL decrement by beats.
REQ-029 Only one burst SHALL be outstanding at a time; ddr_burst_done is honoured only in WAIT and ignored elsewhere.
REQ-030 ddr_burst_done in WAIT SHALL go to ISSUE if remaining>0, otherwise to DONE (done pulse in DONE).
REQ-031 busy SHALL be high in every state except IDLE.
REQ-032 A trigger while busy SHALL be ignored and SHALL set overrun; overrun clears on the next accepted trigger.
REQ-033 A trigger coinciding with the DONE cycle SHALL count as busy (ignored, overrun set).

Reset
REQ-034 On hard_rst, at any time including mid-burst, the block SHALL enter IDLE and clear ddr_cmd_valid, busy, done, err, overrun, and all ddr_cmd_* fields to 0, dropping any in-flight transfer.

Structure
REQ-035 Package yolo_dma_pkg SHALL hold the type codes (0x00, 0x10, 0x20), the reg5 address 0xC0000014, the BEAT_BYTES/MAX_BURST defaults, and the FSM state enum.
REQ-036 Combinational submodule yolo_burst_calc SHALL compute the next burst's beats from remaining, addr[11:0], and MAX_BURST.

Verification
REQ-037 type 0x10, len 1024, addr 0x0000_1000 -> two commands {0x1000, len 15, dir 0} and {0x1200, len 15, dir 0}, then done.
REQ-038 type 0x20, len 100, addr 0x0000_0FC0 -> {0xFC0, len 1, dir 1, to_yolo 1} then {0x1000, len 1}; 4 beats total.
REQ-039 type 0x05, len 64 -> err pulse, no ddr_cmd_valid; addr 0x...0004 with type 0x00 -> err pulse.
REQ-040 len 0, type 0x00 -> done two cycles after trigger, no command.
REQ-041 ddr_cmd_ready held low for 10 cycles -> fields stable; trigger during WAIT -> ignored, overrun=1; hard_rst asserted in WAIT -> all outputs 0 next cycle, and a later ddr_burst_done is ignored.
